// File: rtl/fcsr_unit.sv
// RV32F floating-point CSR unit: frm, sticky fflags accrued from LANES FPU lanes, Zicsr access to 0x001..0x003.
// Optional FCSR_IRQ_EN adds an fcsr[12:8] flag-interrupt mask and a registered irq level.
module fcsr_unit #(
  parameter int LANES = 2,
  parameter int XLEN  = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 csr_valid,
  input  logic [1:0]           csr_op,
  input  logic [11:0]          csr_addr,
  input  logic [XLEN-1:0]      csr_wdata,
  output logic [XLEN-1:0]      csr_rdata,
  output logic                 csr_rvalid,
  output logic                 csr_err,
  input  logic [LANES-1:0]     exc_valid,
  input  logic [5*LANES-1:0]   exc_flags,
  input  logic [2:0]           instr_rm,
  output logic [2:0]           rm_eff,
  output logic                 rm_illegal,
  output logic [2:0]           frm,
  output logic [4:0]           fflags,
  output logic [31:0]          fcsr_status,
  output logic                 irq
);

  localparam logic [11:0] ADDR_FFLAGS = 12'h001;
  localparam logic [11:0] ADDR_FRM    = 12'h002;
  localparam logic [11:0] ADDR_FCSR   = 12'h003;
  localparam logic [1:0]  OP_RW = 2'b01;
  localparam logic [1:0]  OP_RS = 2'b10;
  localparam logic [1:0]  OP_RC = 2'b11;

  function automatic logic [4:0] csr_apply(input logic [1:0] op, input logic [4:0] old_v,
                                           input logic [4:0] opnd);
    case (op)
      OP_RW:   csr_apply = opnd;
      OP_RS:   csr_apply = old_v | opnd;
      OP_RC:   csr_apply = old_v & ~opnd;
      default: csr_apply = old_v;
    endcase
  endfunction

  logic [2:0]      frm_q, frm_d;
  logic [4:0]      fflags_q, fflags_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            rvalid_q, err_q, err_d;
  logic [4:0]      mask_v, mask_d, acc, frm_w, ff_csr;
  logic            addr_ok, sel_ff, sel_frm;
  logic            unused_wdata;

  always_comb begin
    acc = '0;
    for (int i = 0; i < LANES; i++)
      if (exc_valid[i]) acc |= exc_flags[5*i +: 5];
  end

  always_comb begin
    addr_ok = (csr_addr == ADDR_FFLAGS) || (csr_addr == ADDR_FRM) || (csr_addr == ADDR_FCSR);
    sel_ff  = csr_valid && ((csr_addr == ADDR_FFLAGS) || (csr_addr == ADDR_FCSR));
    sel_frm = csr_valid && ((csr_addr == ADDR_FRM) || (csr_addr == ADDR_FCSR));

    ff_csr = sel_ff ? csr_apply(csr_op, fflags_q, csr_wdata[4:0]) : fflags_q;
    // Accrual is OR-ed in after the CSR write so a same-cycle clear cannot drop a new flag.
    fflags_d = ff_csr | acc;

    frm_w = csr_apply(csr_op, {2'b00, frm_q},
                      {2'b00, (csr_addr == ADDR_FCSR) ? csr_wdata[7:5] : csr_wdata[2:0]});
    frm_d = sel_frm ? frm_w[2:0] : frm_q;

    rdata_d = '0;
    case (csr_addr)
      ADDR_FFLAGS: rdata_d[4:0]  = fflags_q;
      ADDR_FRM:    rdata_d[2:0]  = frm_q;
      ADDR_FCSR:   rdata_d[12:0] = {mask_v, frm_q, fflags_q};
      default:     rdata_d       = '0;
    endcase
    err_d = csr_valid && !addr_ok;
  end

`ifdef FCSR_IRQ_EN
  logic [4:0] mask_q;
  logic       irq_q;

  always_comb begin
    mask_d = mask_q;
    if (csr_valid && (csr_addr == ADDR_FCSR))
      mask_d = csr_apply(csr_op, mask_q, csr_wdata[12:8]);
  end

  // irq tracks the next-state flags and mask so it lines up with fflags/fcsr_status.
  always_ff @(posedge clock) begin
    if (!reset) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_q  <= |(fflags_d & mask_d);
    end
  end

  assign mask_v       = mask_q;
  assign irq          = irq_q;
  assign unused_wdata = ^csr_wdata[XLEN-1:13];
`else
  assign mask_d       = '0;
  assign mask_v       = mask_d;
  assign irq          = 1'b0;
  assign unused_wdata = ^csr_wdata[XLEN-1:8];
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      frm_q    <= '0;
      fflags_q <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      frm_q    <= frm_d;
      fflags_q <= fflags_d;
      rdata_q  <= csr_valid ? rdata_d : '0;
      rvalid_q <= csr_valid;
      err_q    <= err_d;
    end
  end

  assign csr_rdata   = rdata_q;
  assign csr_rvalid  = rvalid_q;
  assign csr_err     = err_q;
  assign frm         = frm_q;
  assign fflags      = fflags_q;
  assign fcsr_status = {19'b0, mask_v, frm_q, fflags_q};

  assign rm_eff     = (instr_rm == 3'b111) ? frm_q : instr_rm;
  assign rm_illegal = (rm_eff >= 3'd5);

endmodule
